// File: rtl/down_counter_cbi_cbo.sv
// down_counter_cbi_cbo: cascadable down counter with borrow chain, load, reload and one-shot halt
module down_counter_cbi_cbo #(
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] RLD_INIT = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             CD,
    input  logic             CBI,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             RLD_WE,
    input  logic [WIDTH-1:0] RLD,
    input  logic             ONESHOT,
    input  logic             UF_CLR,
    output logic [WIDTH-1:0] Q,
    output logic             CBO,
    output logic             UF,
    output logic             RUN
);
    typedef enum logic {COUNT = 1'b0, HALT = 1'b1} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, rld_q, rld_d;
    logic             uf_q, uf_d;
    logic             zero, run, uf_ev;
    assign zero  = q_q == '0;
    assign run   = state_q == COUNT;
    assign uf_ev = run && CBI && zero && !LD;
    always_comb begin
        q_d     = q_q;
        state_d = state_q;
        rld_d   = RLD_WE ? RLD : rld_q;
        uf_d    = uf_ev || (uf_q && !UF_CLR);
        if (LD) begin
            q_d     = D;
            state_d = COUNT;
        end else if (run && CBI) begin
            // underflow reloads the pre-write reload value
            if (!zero)
                q_d = q_q - 1'b1;
            else if (ONESHOT)
                state_d = HALT;
            else
                q_d = rld_q;
        end
    end
    always_ff @(posedge CLK) begin
        if (CD) begin
            q_q     <= '0;
            rld_q   <= RLD_INIT;
            uf_q    <= 1'b0;
            state_q <= COUNT;
        end else begin
            q_q     <= q_d;
            rld_q   <= rld_d;
            uf_q    <= uf_d;
            state_q <= state_d;
        end
    end
    assign Q   = q_q;
    assign UF  = uf_q;
    assign RUN = run;
    assign CBO = CBI && zero && run;
endmodule

// File: tb/tb_down_counter_cbi_cbo.sv
// tb_down_counter_cbi_cbo: directed vector table plus cascade sequence for down_counter_cbi_cbo
module tb_down_counter_cbi_cbo;
    logic       CLK = 1'b0;
    logic       cd = 0, cbi = 0, ld = 0, rld_we = 0, os = 0, uf_clr = 0;
    logic [3:0] d = 0, rld = 0;
    logic [3:0] q;
    logic       cbo, uf, run;
    logic       c_cd = 0, c_cbi = 0, c_ld = 0;
    logic [7:0] c_d = 0;
    logic [3:0] lo_q, hi_q;
    logic       lo_cbo, hi_cbo, lo_uf, hi_uf, lo_run, hi_run;
    int         passed = 0, total = 0;

    typedef struct {
        logic       cd, cbi, ld;
        logic [3:0] d;
        logic       rld_we;
        logic [3:0] rld;
        logic       os, uf_clr;
        logic [3:0] eq;
        logic       euf, erun, ecbo;
    } vec_t;
    vec_t vecs[$];

    always #5 CLK = ~CLK;

    down_counter_cbi_cbo dut (
        .CLK(CLK), .CD(cd), .CBI(cbi), .LD(ld), .D(d), .RLD_WE(rld_we), .RLD(rld),
        .ONESHOT(os), .UF_CLR(uf_clr), .Q(q), .CBO(cbo), .UF(uf), .RUN(run)
    );
    down_counter_cbi_cbo u_lo (
        .CLK(CLK), .CD(c_cd), .CBI(c_cbi), .LD(c_ld), .D(c_d[3:0]), .RLD_WE(1'b0), .RLD(4'h0),
        .ONESHOT(1'b0), .UF_CLR(1'b0), .Q(lo_q), .CBO(lo_cbo), .UF(lo_uf), .RUN(lo_run)
    );
    down_counter_cbi_cbo u_hi (
        .CLK(CLK), .CD(c_cd), .CBI(lo_cbo), .LD(c_ld), .D(c_d[7:4]), .RLD_WE(1'b0), .RLD(4'h0),
        .ONESHOT(1'b0), .UF_CLR(1'b0), .Q(hi_q), .CBO(hi_cbo), .UF(hi_uf), .RUN(hi_run)
    );

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic add(input logic vcd, vcbi, vld, input logic [3:0] vd, input logic vwe,
                       input logic [3:0] vrld, input logic vos, vclr,
                       input logic [3:0] eq, input logic euf, erun, ecbo);
        vecs.push_back('{vcd, vcbi, vld, vd, vwe, vrld, vos, vclr, eq, euf, erun, ecbo});
    endtask

    initial begin
        //   cd cbi ld d    we rld  os clr  Q    UF RUN CBO
        add(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0);
        add(0, 1, 1, 4'h5, 0, 4'h0, 0, 0, 4'h5, 0, 1, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h4, 0, 1, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h3, 0, 1, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h2, 0, 1, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h1, 0, 1, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 1);
        add(0, 0, 1, 4'h1, 1, 4'h9, 0, 0, 4'h1, 0, 1, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 1);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h9, 1, 1, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h8, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 1, 1, 0);
        add(0, 1, 0, 4'h0, 1, 4'h3, 0, 0, 4'h9, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 1, 1, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h3, 1, 1, 0);
        add(0, 0, 0, 4'h0, 0, 4'h0, 0, 1, 4'h3, 0, 1, 0);
        add(0, 0, 1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 1, 4'h3, 1, 1, 0);
        add(0, 0, 0, 4'h0, 0, 4'h0, 0, 1, 4'h3, 0, 1, 0);
        add(0, 0, 1, 4'h2, 0, 4'h0, 1, 0, 4'h2, 0, 1, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 1, 0, 4'h1, 0, 1, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 1, 0, 4'h0, 0, 1, 1);
        add(0, 1, 0, 4'h0, 0, 4'h0, 1, 0, 4'h0, 1, 0, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 1, 0, 0);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 1, 0, 0);
        add(0, 0, 1, 4'h7, 0, 4'h0, 0, 0, 4'h7, 1, 1, 0);
        add(0, 0, 1, 4'h0, 0, 4'h0, 0, 1, 4'h0, 0, 1, 0);
        add(0, 1, 1, 4'hA, 0, 4'h0, 0, 0, 4'hA, 0, 1, 0);
        add(1, 1, 1, 4'h5, 1, 4'h2, 0, 0, 4'h0, 0, 1, 1);
        add(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 4'hF, 1, 1, 0);
        add(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0);

        foreach (vecs[i]) begin
            @(negedge CLK);
            {cd, cbi, ld, d, rld_we, rld, os, uf_clr} =
                {vecs[i].cd, vecs[i].cbi, vecs[i].ld, vecs[i].d, vecs[i].rld_we, vecs[i].rld, vecs[i].os, vecs[i].uf_clr};
            @(posedge CLK); #1;
            chk("Q", i, {4'h0, q}, {4'h0, vecs[i].eq});
            chk("UF", i, {7'h0, uf}, {7'h0, vecs[i].euf});
            chk("RUN", i, {7'h0, run}, {7'h0, vecs[i].erun});
            chk("CBO", i, {7'h0, cbo}, {7'h0, vecs[i].ecbo});
        end

        @(negedge CLK);
        {cd, cbi, ld} = 3'b000;
        c_cd = 1;
        @(posedge CLK); #1;
        chk("casc_reset", 0, {hi_q, lo_q}, 8'h00);
        @(negedge CLK);
        c_cd = 0; c_ld = 1; c_d = 8'h10;
        @(posedge CLK); #1;
        chk("casc_load", 1, {hi_q, lo_q}, 8'h10);
        @(negedge CLK);
        c_ld = 0; c_cbi = 1;
        #1 chk("casc_lo_cbo", 2, {7'h0, lo_cbo}, 8'h01);
        @(posedge CLK); #1;
        chk("casc_dec1", 3, {hi_q, lo_q}, 8'h0F);
        @(posedge CLK); #1;
        chk("casc_dec2", 4, {hi_q, lo_q}, 8'h0E);
        chk("casc_uf_hi_clear", 5, {7'h0, hi_uf}, 8'h00);
        @(negedge CLK);
        c_ld = 1; c_d = 8'h00; c_cbi = 0;
        @(posedge CLK); #1;
        chk("casc_load0", 6, {hi_q, lo_q}, 8'h00);
        @(negedge CLK);
        c_ld = 0; c_cbi = 1;
        #1 chk("casc_hi_cbo", 7, {7'h0, hi_cbo}, 8'h01);
        @(posedge CLK); #1;
        chk("casc_wrap", 8, {hi_q, lo_q}, 8'hFF);
        chk("casc_uf", 9, {6'h0, hi_uf, lo_uf}, 8'h03);
        chk("casc_run", 10, {6'h0, hi_run, lo_run}, 8'h03);
        @(negedge CLK);
        c_cbi = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
